booth_seq_divider: RTL and testbench
====================================

// Module: booth_seq_divider
// PURPOSE
//   Sequential signed integer divider: the inverse of the team's combinational Booth
//   multiplier. Computes quotient and remainder of two N-bit two's-complement operands,
//   one quotient bit per clock (restoring division on magnitudes, then sign fix-up).
//   Sits beside booth_multiplier in the arithmetic library; uses a start/done handshake.
// PARAMETERS
//   N  default 4  operand/result width in bits (N >= 2)
// PORTS
//   clk          input   1  single clock; all state changes on rising edge
//   rst          input   1  synchronous, active-high reset
//   start        input   1  request a division; sampled only in IDLE
//   dividend     input   N  signed dividend, captured on accepted start
//   divisor      input   N  signed divisor, captured on accepted start
//   quotient     output  N  signed quotient, truncated toward zero
//   remainder    output  N  signed remainder; sign follows dividend (or zero)
//   busy         output  1  high while in CALC
//   done         output  1  one-cycle pulse: quotient/remainder/flags valid and updated
//   div_by_zero  output  1  divisor was 0 for the result flagged by done
//   overflow     output  1  dividend = -2^(N-1) and divisor = -1
// BEHAVIOUR
//   Reset (clk edge with rst=1): state=IDLE; quotient, remainder, done, busy,
//     div_by_zero and overflow = 0. rst wins over every other input, including mid-CALC
//     (operation abandoned, no done pulse).
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on edge with start=1, capture |dividend|, |divisor| (N+1-bit magnitudes so
//     |-2^(N-1)| is exact), sign_q = dividend[N-1]^divisor[N-1], sign_r = dividend[N-1],
//     partial remainder=0, count=0 -> CALC. If divisor==0: skip CALC, go to DONE with
//     quotient = all ones (-1), remainder = dividend, div_by_zero=1.
//   CALC: each edge shift {rem,quo} left 1, trial subtract |divisor| from rem;
//     if non-negative keep and set quo LSB=1, else restore. count increments.
//     On edge where count==N-1: apply sign fix (negate quo if sign_q, negate rem if
//     sign_r), register outputs, set flags -> DONE.
//   DONE: done=1 for exactly this one cycle; next edge -> IDLE. start ignored.
//   Latency: start edge at t0 -> done high in cycle after edge t0+N (t0+1 for div-by-0).
//   Throughput: a new start is accepted in IDLE, i.e. at earliest one cycle after done.
//   start while busy or in DONE is ignored (not queued); operand inputs only matter on
//     the accepting edge.
//   Overflow case -2^(N-1) / -1: quotient = -2^(N-1) (wraps), remainder=0, overflow=1.
//   Flags are 0 for normal results; flags and data hold their value until the next done.
//   Width rules: magnitudes and partial remainder are N+1 bits; outputs truncate to N.
//   Invariant for non-flagged results: dividend == quotient*divisor + remainder,
//     |remainder| < |divisor|.
// TESTING (N=4 unless stated)
//   1 7/2 start at t0 -> done at t0+4 cycle: quotient=3, remainder=1, flags 0, busy 3 cycles.
//   2 Signs: -7/2 -> q=-3 r=-1; 7/-2 -> q=-3 r=1; -7/-2 -> q=3 r=-1; 0/5 -> q=0 r=0.
//   3 -8/-1 -> quotient=-8, remainder=0, overflow=1; -8/1 -> q=-8, r=0, overflow=0.
//   4 5/0 -> done one cycle after start edge, quotient=-1, remainder=5, div_by_zero=1.
//   5 start pulsed every cycle with changing operands -> only first-accepted operands
//     produce a result; next accepted start is first one in IDLE after done.
//   6 rst asserted two cycles into CALC -> next cycle all outputs 0, no done pulse;
//     fresh 6/3 afterwards -> q=2 r=0. Plus random exhaustive N=4 vs. reference model.

Source files
------------

// File: rtl/booth_seq_divider_if.sv
// Start/done operand and result bundle for booth_seq_divider.
// master drives requests, slave returns results and status.
interface booth_seq_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/booth_seq_divider.sv
// Sequential signed divider, one quotient bit per clock; done pulses N+1 cycles after start (1 for /0).
// No queuing: start is sampled only in IDLE, requests while busy or done are dropped.
module booth_seq_divider #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_seq_divider_if.slave   bus
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN_VAL  = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N:0]    dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [N+1:0]  rem_sh;
  logic [N+1:0]  diff;
  logic [N:0]    rem_nx;
  logic [N-1:0]  quo_nx;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  // Unsigned magnitude in N bits; |-2^(N-1)| = 2^(N-1) still fits unsigned.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    // One restoring step: shift next dividend bit into the partial remainder.
    rem_sh = {rem_q, quo_q[N-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_nx = rem_sh[N:0];
    quo_nx = {quo_q[N-2:0], 1'b0};
    if (!diff[N+1]) begin
      rem_nx    = diff[N:0];
      quo_nx[0] = 1'b1;
    end
    q_fix = neg_quo_q ? -quo_nx : quo_nx;
    r_fix = neg_rem_q ? -rem_nx[N-1:0] : rem_nx[N-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            quo_d      = mag(bus.dividend);
            dvs_d      = {1'b0, mag(bus.divisor)};
            rem_d      = '0;
            cnt_d      = '0;
            neg_quo_d  = bus.dividend[N-1] ^ bus.divisor[N-1];
            neg_rem_d  = bus.dividend[N-1];
            ovf_pend_d = (bus.dividend == MIN_VAL) && (bus.divisor == '1);
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
          dbz_d       = 1'b0;
          ovf_d       = ovf_pend_q;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = (state_q == S_CALC);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench for booth_seq_divider (N=4): directed vector table, handshake corner cases,
// exhaustive operand sweep and random operands against an arithmetic reference model.
module tb_booth_seq_divider;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_seq_divider_if #(.N(N)) bus ();

  booth_seq_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int errors = 0;
  logic [3:0] cur_a, cur_b;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (a=%0h b=%0h): got %0h expected %0h", nm, cur_a, cur_b, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic, truncating division, remainder sign follows dividend.
  task automatic ref_div(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic dz, output logic ov);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q  = 4'hF;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = 4'(sa / sb);
      r  = 4'(sa % sb);
      ov = (sa == -8) && (sb == -1);
    end
  endtask

  // Issues one request from IDLE, waits (bounded) for done, then steps back to IDLE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dz, output logic ov, output int lat,
                        output logic busy1, output logic busy_done);
    cur_a = a;
    cur_b = b;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat   = 0;
    busy1 = bus.busy;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q         = bus.quotient;
    r         = bus.remainder;
    dz        = bus.div_by_zero;
    ov        = bus.overflow;
    busy_done = bus.busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] q, r, eq, er;
    logic dz, ov, edz, eov, b1, bd;
    int lat, done_seen;

    vecs[0]  = '{4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0};
    vecs[1]  = '{4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0};
    vecs[2]  = '{4'd7, 4'hE, 4'hD, 4'd1, 1'b0, 1'b0};
    vecs[3]  = '{4'h9, 4'hE, 4'd3, 4'hF, 1'b0, 1'b0};
    vecs[4]  = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'h8, 4'hF, 4'h8, 4'd0, 1'b0, 1'b1};
    vecs[6]  = '{4'h8, 4'd1, 4'h8, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1'b0};
    vecs[8]  = '{4'h8, 4'd0, 4'hF, 4'h8, 1'b1, 1'b0};
    vecs[9]  = '{4'd1, 4'd7, 4'd0, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{4'd7, 4'd7, 4'd1, 4'd0, 1'b0, 1'b0};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    cur_a = '0;
    cur_b = '0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", int'(bus.quotient), 0);
    chk("reset_remainder", int'(bus.remainder), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_dbz", int'(bus.div_by_zero), 0);
    chk("reset_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, ov, lat, b1, bd);
      chk("vec_quotient", int'(q), int'(vecs[i].q));
      chk("vec_remainder", int'(r), int'(vecs[i].r));
      chk("vec_dbz", int'(dz), int'(vecs[i].dz));
      chk("vec_ovf", int'(ov), int'(vecs[i].ov));
      chk("vec_latency", lat, (vecs[i].b == 4'd0) ? 0 : N);
      chk("vec_busy_after_start", int'(b1), (vecs[i].b == 4'd0) ? 0 : 1);
      chk("vec_busy_at_done", int'(bd), 0);
    end

    // start held high with changing operands: only accepted operands count
    cur_a = 4'd7;
    cur_b = 4'd2;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd2;
    @(posedge clk);
    #1;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      bus.dividend = 4'($urandom);
      bus.divisor  = 4'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("held_first_latency", lat, N);
    chk("held_first_quotient", int'(bus.quotient), 3);
    chk("held_first_remainder", int'(bus.remainder), 1);
    @(negedge clk);
    bus.dividend = 4'd6;
    bus.divisor  = 4'd3;
    @(posedge clk);
    #1;
    chk("held_done_one_cycle", int'(bus.done), 0);
    chk("held_ignored_in_done", int'(bus.busy), 0);
    cur_a = 4'h9;
    cur_b = 4'd2;
    @(negedge clk);
    bus.dividend = 4'h9;
    bus.divisor  = 4'd2;
    @(posedge clk);
    #1;
    chk("held_accept_in_idle", int'(bus.busy), 1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      bus.dividend = 4'($urandom);
      bus.divisor  = 4'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("held_second_latency", lat, N);
    chk("held_second_quotient", int'(bus.quotient), 4'hD);
    chk("held_second_remainder", int'(bus.remainder), 4'hF);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-calculation abandons the operation; flags from a prior /0 are cleared
    run_op(4'd5, 4'd0, q, r, dz, ov, lat, b1, bd);
    chk("pre_reset_dbz", int'(dz), 1);
    cur_a = 4'h9;
    cur_b = 4'd2;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'h9;
    bus.divisor  = 4'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_quotient", int'(bus.quotient), 0);
    chk("midrst_remainder", int'(bus.remainder), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_dbz", int'(bus.div_by_zero), 0);
    chk("midrst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    run_op(4'd6, 4'd3, q, r, dz, ov, lat, b1, bd);
    chk("post_rst_quotient", int'(q), 2);
    chk("post_rst_remainder", int'(r), 0);
    chk("post_rst_latency", lat, N);

    // Exhaustive operand sweep against the reference model
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_op(4'(ai), 4'(bi), q, r, dz, ov, lat, b1, bd);
        ref_div(4'(ai), 4'(bi), eq, er, edz, eov);
        chk("sweep_quotient", int'(q), int'(eq));
        chk("sweep_remainder", int'(r), int'(er));
        chk("sweep_dbz", int'(dz), int'(edz));
        chk("sweep_ovf", int'(ov), int'(eov));
      end
    end

    // Random operands
    for (int k = 0; k < 100; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ra, rb, q, r, dz, ov, lat, b1, bd);
      ref_div(ra, rb, eq, er, edz, eov);
      chk("rand_quotient", int'(q), int'(eq));
      chk("rand_remainder", int'(r), int'(er));
      chk("rand_flags", int'({dz, ov}), int'({edz, eov}));
      chk("rand_latency", lat, (rb == 4'd0) ? 0 : N);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
